// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants: word width, stream-mux mode codes and a
// select-width helper used by the stream mux and its arbiter.
package cpu_pkg;

    localparam int WORD_W       = 16;
    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    typedef enum logic {
        MUX_SEL = 1'b0,
        MUX_RR  = 1'b1
    } mux_mode_e;

    // Width of an index able to name every one of n channels.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last winner.
// The pointer moves only when the granted request is actually consumed.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = sel_width(NCH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NCH-1:0]  req,
    input  logic            advance,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] idx
);

    logic [SELW-1:0] ptr_q;
    logic [SELW-1:0] ptr_d;
    logic            found;
    int              cand;

    // Search ptr+1, ptr+2, ... wrapping past NCH-1 back to channel 0.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NCH; off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= NCH) begin
                cand = cand - NCH;
            end
            for (int i = 0; i < NCH; i++) begin
                if (!found && (i == cand) && req[i]) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= SELW'(NCH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 word multiplexer with a registered output and valid/ready handshake;
// channel picked by sel or by round-robin over requesting channels.
module stream_mux_rr
    import cpu_pkg::*;
#(
    parameter  int WIDTH   = WORD_W,
    parameter  int NCH     = 4,
    parameter  int RR_MODE = MUX_MODE_SEL,
    localparam int SELW    = sel_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic [NCH-1:0]   grant;
    logic [SELW-1:0]  grant_idx;
    logic             load_en;
    logic             load;
    logic [WIDTH-1:0] sel_word;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;

    // Output stage can accept a word when empty or being drained this cycle.
    assign load_en = !out_valid_q || out_ready;

    generate
        if (RR_MODE == MUX_MODE_RR) begin : g_rr
            logic sel_unused;
            assign sel_unused = ^sel;

            rr_arbiter #(
                .NCH (NCH)
            ) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (in_valid),
                .advance (load),
                .grant   (grant),
                .idx     (grant_idx)
            );
        end else begin : g_sel
            // Out-of-range sel leaves grant empty, so nothing is accepted.
            always_comb begin
                grant = '0;
                for (int i = 0; i < NCH; i++) begin
                    if (int'(sel) == i) begin
                        grant[i] = 1'b1;
                    end
                end
            end
            assign grant_idx = sel;
        end
    endgenerate

    assign load     = load_en && |(grant & in_valid);
    assign in_ready = rst_n ? (grant & {NCH{load_en}}) : '0;

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant[i]) begin
                sel_word = sel_word | in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Drain and load in the same cycle gives back-to-back words.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_word;
            out_ch_d    = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: select mode (4 and 5 channels) and
// round-robin mode, plus a randomised no-loss/no-duplication scoreboard.
module tb_stream_mux_rr;

    logic clk;
    logic rst_n;

    // select mode, 4 channels
    logic [15:0] a_w [4];
    logic [63:0] a_in_data;
    logic [3:0]  a_in_valid, a_in_ready;
    logic [1:0]  a_sel, a_out_ch;
    logic [15:0] a_out_data;
    logic        a_out_valid, a_out_ready;

    // round-robin mode, 4 channels
    logic [15:0] b_w [4];
    logic [63:0] b_in_data;
    logic [3:0]  b_in_valid, b_in_ready;
    logic [1:0]  b_sel, b_out_ch;
    logic [15:0] b_out_data;
    logic        b_out_valid, b_out_ready;

    // select mode, 5 channels (3-bit sel)
    logic [15:0] c_w [5];
    logic [79:0] c_in_data;
    logic [4:0]  c_in_valid, c_in_ready;
    logic [2:0]  c_sel, c_out_ch;
    logic [15:0] c_out_data;
    logic        c_out_valid, c_out_ready;

    int n_assert;
    int n_fail;

    assign a_in_data = {a_w[3], a_w[2], a_w[1], a_w[0]};
    assign b_in_data = {b_w[3], b_w[2], b_w[1], b_w[0]};
    assign c_in_data = {c_w[4], c_w[3], c_w[2], c_w[1], c_w[0]};

    stream_mux_rr #(.WIDTH(16), .NCH(4), .RR_MODE(0)) u_dut_sel (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .sel(a_sel), .out_data(a_out_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ch(a_out_ch)
    );

    stream_mux_rr #(.WIDTH(16), .NCH(4), .RR_MODE(1)) u_dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .sel(b_sel), .out_data(b_out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ch(b_out_ch)
    );

    stream_mux_rr #(.WIDTH(16), .NCH(5), .RR_MODE(0)) u_dut_sel5 (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .sel(c_sel), .out_data(c_out_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_ch(c_out_ch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] sb [$];
    logic [15:0] exp_w;
    logic [3:0]  pend;
    logic [11:0] seq [4];
    int          n_acc;
    int          n_out;

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_w[i] = '0;
            b_w[i] = '0;
            seq[i] = '0;
        end
        for (int i = 0; i < 5; i++) c_w[i] = '0;
        a_in_valid = '0; a_sel = '0; a_out_ready = 1'b0;
        b_in_valid = '0; b_sel = '0; b_out_ready = 1'b0;
        c_in_valid = '0; c_sel = '0; c_out_ready = 1'b0;

        // Reset state
        #1;
        chk("rst_a_valid", 32'(a_out_valid), 32'h0);
        chk("rst_a_data",  32'(a_out_data),  32'h0);
        chk("rst_a_ch",    32'(a_out_ch),    32'h0);
        chk("rst_a_ready", 32'(a_in_ready),  32'h0);
        chk("rst_b_valid", 32'(b_out_valid), 32'h0);
        chk("rst_c_valid", 32'(c_out_valid), 32'h0);
        #11;
        rst_n = 1'b1;
        tick();

        // Select mode: sel=2 carries BEEF, then one word per cycle
        a_sel = 2'd2; a_in_valid = 4'b0100; a_w[2] = 16'hBEEF; a_out_ready = 1'b1;
        #1;
        chk("sel_ready_ch2", 32'(a_in_ready), 32'h4);
        tick();
        chk("sel_data_beef", 32'(a_out_data),  32'hBEEF);
        chk("sel_ch_2",      32'(a_out_ch),    32'h2);
        chk("sel_valid",     32'(a_out_valid), 32'h1);
        a_w[2] = 16'h1234;
        tick();
        chk("sel_b2b_1", 32'(a_out_data), 32'h1234);
        a_w[2] = 16'h5678;
        tick();
        chk("sel_b2b_2", 32'(a_out_data), 32'h5678);

        // Stall with a sel change underneath
        a_out_ready = 1'b0; a_sel = 2'd1; a_in_valid = 4'b0010; a_w[1] = 16'hC0DE;
        #1;
        chk("stall_ready0", 32'(a_in_ready), 32'h0);
        repeat (3) begin
            tick();
            chk("stall_data",  32'(a_out_data),  32'h5678);
            chk("stall_ch",    32'(a_out_ch),    32'h2);
            chk("stall_valid", 32'(a_out_valid), 32'h1);
            chk("stall_ready", 32'(a_in_ready),  32'h0);
        end
        a_out_ready = 1'b1;
        #1;
        chk("release_ready_ch1", 32'(a_in_ready), 32'h2);
        tick();
        chk("release_data", 32'(a_out_data), 32'hC0DE);
        chk("release_ch",   32'(a_out_ch),   32'h1);
        a_in_valid = 4'b0000;
        tick();
        chk("drain_valid0", 32'(a_out_valid), 32'h0);
        chk("drain_hold_d", 32'(a_out_data),  32'hC0DE);
        chk("drain_hold_c", 32'(a_out_ch),    32'h1);

        // Five channels: out-of-range sel loads nothing
        c_sel = 3'd4; c_in_valid = 5'b10000; c_w[4] = 16'hA5A5; c_out_ready = 1'b1;
        #1;
        chk("sel5_ready_ch4", 32'(c_in_ready), 32'h10);
        tick();
        chk("sel5_data", 32'(c_out_data), 32'hA5A5);
        chk("sel5_ch",   32'(c_out_ch),   32'h4);
        c_sel = 3'd5; c_in_valid = 5'b11111;
        #1;
        chk("oor5_ready", 32'(c_in_ready), 32'h0);
        tick();
        chk("oor5_valid0", 32'(c_out_valid), 32'h0);
        chk("oor5_hold_d", 32'(c_out_data),  32'hA5A5);
        chk("oor5_hold_c", 32'(c_out_ch),    32'h4);
        c_sel = 3'd7;
        tick();
        chk("oor7_valid0", 32'(c_out_valid), 32'h0);
        chk("oor7_ready",  32'(c_in_ready),  32'h0);
        c_sel = 3'd0;
        #1;
        chk("sel5_ready_ch0", 32'(c_in_ready), 32'h1);
        c_in_valid = 5'b00000;

        // Round-robin: all valid, then only ch1 and ch3
        for (int i = 0; i < 4; i++) b_w[i] = 16'h1000 + 16'(i);
        b_in_valid = 4'b1111; b_out_ready = 1'b1;
        #1;
        chk("rr_first_ready", 32'(b_in_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("rr_all_ch",   32'(b_out_ch),   32'(k % 4));
            chk("rr_all_data", 32'(b_out_data), 32'h1000 + 32'(k % 4));
        end
        b_in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_13_ch", 32'(b_out_ch), (k % 2 == 0) ? 32'h1 : 32'h3);
        end

        // Round-robin stall freezes the pointer
        b_in_valid = 4'b0100;
        tick();
        chk("rr_grant2", 32'(b_out_ch), 32'h2);
        b_out_ready = 1'b0; b_in_valid = 4'b1111;
        #1;
        chk("rr_stall_ready", 32'(b_in_ready), 32'h0);
        repeat (2) begin
            tick();
            chk("rr_stall_ch",   32'(b_out_ch),   32'h2);
            chk("rr_stall_data", 32'(b_out_data), 32'h1002);
        end
        b_out_ready = 1'b1;
        #1;
        chk("rr_release_ready", 32'(b_in_ready), 32'h8);
        tick();
        chk("rr_release_ch",   32'(b_out_ch),   32'h3);
        chk("rr_release_data", 32'(b_out_data), 32'h1003);

        // Asynchronous reset while holding a word
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(b_out_valid), 32'h0);
        chk("arst_data",  32'(b_out_data),  32'h0);
        chk("arst_ch",    32'(b_out_ch),    32'h0);
        chk("arst_ready", 32'(b_in_ready),  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("arst_restart_ch",   32'(b_out_ch),   32'h0);
        chk("arst_restart_data", 32'(b_out_data), 32'h1000);

        // Random valid/ready with a scoreboard
        b_in_valid = 4'b0000;
        tick();
        tick();
        chk("rr_idle", 32'(b_out_valid), 32'h0);
        pend  = '0;
        n_acc = 0;
        n_out = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) != 0)) begin
                    pend[i] = 1'b1;
                    b_w[i]  = {4'(i), seq[i]};
                end
            end
            b_in_valid  = pend;
            b_out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk("rr_onehot", 32'($countones(b_in_ready) <= 1), 32'h1);
            if (b_out_valid && b_out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_spurious", 32'(b_out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_w = sb.pop_front();
                    chk("sb_data", 32'(b_out_data), 32'(exp_w));
                    chk("sb_ch",   32'(b_out_ch),   32'(exp_w[15:12]));
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (b_in_valid[i] && b_in_ready[i]) begin
                    sb.push_back(b_w[i]);
                    n_acc++;
                    pend[i] = 1'b0;
                    seq[i]  = seq[i] + 12'd1;
                end
            end
            @(posedge clk);
            #1;
        end
        b_in_valid  = 4'b0000;
        b_out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (b_out_valid) begin
                n_out++;
                if (sb.size() == 0) begin
                    chk("sb_spurious", 32'(b_out_data), 32'hFFFF_FFFF);
                end else begin
                    exp_w = sb.pop_front();
                    chk("sb_drain_data", 32'(b_out_data), 32'(exp_w));
                end
            end
            @(posedge clk);
            #1;
        end
        chk("sb_empty", 32'(sb.size()), 32'h0);
        chk("sb_count", 32'(n_out), 32'(n_acc));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
